// File: rtl/cpu_pkg.sv
// Shared definitions for the forwarding/hazard block: select codes, pipeline slot layout
// and the register-match rule used by both the forward and stall logic.
package cpu_pkg;
  localparam int REG_W = 4;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MERGE = 2'b11;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic             lhb;
    logic [REG_W-1:0] rd;
  } slot_t;

  typedef struct packed {
    slot_t            s;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rs;
    logic             uses_rt;
  } ex_slot_t;

  // R0 is hardwired to zero, so a writer to R0 never produces a forwardable value.
  function automatic logic slot_match(slot_t s, logic [REG_W-1:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != '0);
  endfunction
endpackage

// File: rtl/fwd_select.sv
// Per-operand forward select: picks the youngest in-flight producer of one EX source register.
module fwd_select
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             uses,
  input  slot_t            mem_s,
  input  slot_t            wb_s,
  output logic [1:0]       code
);
  logic mem_hit;
  logic wb_hit;

  assign mem_hit = uses && slot_match(mem_s, src);
  assign wb_hit  = uses && slot_match(wb_s, src);

  // A load still in MEM has no data yet; the load-use stall guarantees it is in WB instead.
  always_comb begin
    code = FWD_REG;
    if (mem_hit && mem_s.lhb && wb_hit)  code = FWD_MERGE;
    else if (mem_hit && !mem_s.memread)  code = FWD_EXMEM;
    else if (wb_hit)                     code = FWD_MEMWB;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks destination info for EX/MEM/WB, drives the EX forward selects, the load-use
// stall and a saturating stall-cycle counter.
module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_lhb,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);
  ex_slot_t ex_s;
  ex_slot_t ex_next;
  slot_t    mem_s;
  slot_t    wb_s;
  logic     load_use;

  fwd_select u_fwd_a (
    .src   (ex_s.rs),
    .uses  (ex_s.uses_rs),
    .mem_s (mem_s),
    .wb_s  (wb_s),
    .code  (forwardA)
  );

  fwd_select u_fwd_b (
    .src   (ex_s.rt),
    .uses  (ex_s.uses_rt),
    .mem_s (mem_s),
    .wb_s  (wb_s),
    .code  (forwardB)
  );

  assign load_use = id_valid && ex_s.s.valid && ex_s.s.memread && ex_s.s.regwrite &&
                    (ex_s.s.rd != '0) &&
                    ((id_uses_rs && (ex_s.s.rd == id_rs)) ||
                     (id_uses_rt && (ex_s.s.rd == id_rt)));

  // A frozen pipeline cannot insert a bubble, so hold masks the stall.
  assign stall = load_use && !hold;

  always_comb begin
    ex_next = '0;
    if (!(flush || stall)) begin
      ex_next.s.valid    = id_valid;
      ex_next.s.regwrite = id_regwrite;
      ex_next.s.memread  = id_memread;
      ex_next.s.lhb      = id_lhb;
      ex_next.s.rd       = id_rd;
      ex_next.rs         = id_rs;
      ex_next.rt         = id_rt;
      ex_next.uses_rs    = id_uses_rs;
      ex_next.uses_rt    = id_uses_rt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_s      <= '0;
      mem_s     <= '0;
      wb_s      <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      wb_s  <= mem_s;
      mem_s <= ex_s.s;
      ex_s  <= ex_next;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a cycle-by-cycle instruction table with hand-derived expected
// outputs, plus directed sequences for reset, counter saturation and stall timing.
module tb_fwd_hazard_unit;
  import cpu_pkg::*;

  localparam int EXP_W = 24;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_lhb;
  logic             flush;
  logic             hold;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic             stall;
  logic [15:0]      stall_cnt;
  logic [1:0]       s_forwardA;
  logic [1:0]       s_forwardB;
  logic             s_stall;
  logic [2:0]       s_stall_cnt;

  int total;
  int bad;
  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic       v;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic [3:0] rd;
    logic       rw;
    logic       mr;
    logic       lhb;
    logic       fl;
    logic       hd;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_lhb(id_lhb),
    .flush(flush), .hold(hold), .forwardA(forwardA), .forwardB(forwardB),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy on the same stimulus, so saturation is reachable in few cycles.
  fwd_hazard_unit #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_lhb(id_lhb),
    .flush(flush), .hold(hold), .forwardA(s_forwardA), .forwardB(s_forwardB),
    .stall(s_stall), .stall_cnt(s_stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [3:0] rs, logic [3:0] rt, logic urs, logic urt,
                              logic [3:0] rd, logic rw, logic mr, logic lhb,
                              logic [1:0] fa, logic [1:0] fb, logic st, logic [15:0] cnt);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.rd = rd;
    r.rw = rw; r.mr = mr; r.lhb = lhb; r.fl = 1'b0; r.hd = 1'b0;
    r.fa = fa; r.fb = fb; r.st = st; r.cnt = cnt;
    return r;
  endfunction

  function automatic vec_t alu(logic [3:0] rd, logic [3:0] rs, logic [3:0] rt,
                               logic [1:0] fa, logic [1:0] fb, logic st, logic [15:0] cnt);
    return mk(1, rs, rt, 1, 1, rd, 1, 0, 0, fa, fb, st, cnt);
  endfunction

  function automatic vec_t ldw(logic [3:0] rd, logic [3:0] rs,
                               logic [1:0] fa, logic [1:0] fb, logic st, logic [15:0] cnt);
    return mk(1, rs, 4'd0, 1, 0, rd, 1, 1, 0, fa, fb, st, cnt);
  endfunction

  function automatic vec_t lhbi(logic [3:0] rd, logic [1:0] fa, logic [1:0] fb,
                                logic st, logic [15:0] cnt);
    return mk(1, 4'd0, 4'd0, 0, 0, rd, 1, 0, 1, fa, fb, st, cnt);
  endfunction

  function automatic vec_t nop(logic [1:0] fa, logic [1:0] fb, logic st, logic [15:0] cnt);
    return mk(0, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, fa, fb, st, cnt);
  endfunction

  function automatic logic [2:0] sat3(logic [15:0] c);
    return (c > 16'd7) ? 3'd7 : c[2:0];
  endfunction

  // driver tasks
  task automatic drive(vec_t r);
    id_valid = r.v; id_rs = r.rs; id_rt = r.rt; id_uses_rs = r.urs; id_uses_rt = r.urt;
    id_rd = r.rd; id_regwrite = r.rw; id_memread = r.mr; id_lhb = r.lhb;
    flush = r.fl; hold = r.hd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: expected outputs queued when a row is driven, popped when sampled
  task automatic run_row(int idx, vec_t r);
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    drive(r);
    exp_q.push_back({r.fa, r.fb, r.st, r.cnt, sat3(r.cnt)});
    #3;
    a = {forwardA, forwardB, stall, stall_cnt, s_stall_cnt};
    e = exp_q.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL row%0d: got fa=%b fb=%b st=%b cnt=%0d cnt3=%0d expected fa=%b fb=%b st=%b cnt=%0d cnt3=%0d",
               idx, a[23:22], a[21:20], a[19], a[18:3], a[2:0],
               e[23:22], e[21:20], e[19], e[18:3], e[2:0]);
    end
    tick();
  endtask

  initial begin
    int e_cnt;
    total = 0;
    bad = 0;
    rst = 1'b1;
    drive(nop(0, 0, 0, 0));

    // EX_MEM forward
    tbl.push_back(alu(3, 1, 2, 2'b00, 2'b00, 0, 0));
    tbl.push_back(alu(5, 3, 4, 2'b00, 2'b00, 0, 0));
    tbl.push_back(nop(2'b10, 2'b00, 0, 0));
    tbl.push_back(nop(2'b00, 2'b00, 0, 0));
    tbl.push_back(nop(2'b00, 2'b00, 0, 0));
    // MEM_WB forward
    tbl.push_back(alu(3, 1, 2, 2'b00, 2'b00, 0, 0));
    tbl.push_back(nop(2'b00, 2'b00, 0, 0));
    tbl.push_back(alu(6, 3, 3, 2'b00, 2'b00, 0, 0));
    tbl.push_back(nop(2'b01, 2'b01, 0, 0));
    // youngest producer wins; R0 operand never forwards
    tbl.push_back(alu(3, 1, 2, 2'b00, 2'b00, 0, 0));
    tbl.push_back(alu(3, 1, 2, 2'b00, 2'b00, 0, 0));
    tbl.push_back(alu(8, 3, 0, 2'b00, 2'b00, 0, 0));
    tbl.push_back(nop(2'b10, 2'b00, 0, 0));
    // load-use: one stall cycle, then MEM_WB forward
    tbl.push_back(ldw(2, 9, 2'b00, 2'b00, 0, 0));
    tbl.push_back(alu(7, 2, 1, 2'b00, 2'b00, 1, 0));
    tbl.push_back(alu(7, 2, 1, 2'b00, 2'b00, 0, 1));
    tbl.push_back(nop(2'b01, 2'b00, 0, 1));
    // LHB merge
    tbl.push_back(alu(4, 1, 1, 2'b00, 2'b00, 0, 1));
    tbl.push_back(lhbi(4, 2'b00, 2'b00, 0, 1));
    tbl.push_back(alu(10, 4, 4, 2'b00, 2'b00, 0, 1));
    tbl.push_back(nop(2'b11, 2'b11, 0, 1));
    // writers to R0: no forward, no stall
    tbl.push_back(alu(0, 1, 1, 2'b00, 2'b00, 0, 1));
    tbl.push_back(ldw(0, 1, 2'b00, 2'b00, 0, 1));
    tbl.push_back(alu(11, 0, 0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(nop(2'b00, 2'b00, 0, 1));
    // flush together with stall: one bubble, one count
    tbl.push_back(ldw(5, 1, 2'b00, 2'b00, 0, 1));
    tbl.push_back(alu(12, 5, 1, 2'b00, 2'b00, 1, 1));
    tbl[tbl.size()-1].fl = 1'b1;
    tbl.push_back(nop(2'b00, 2'b00, 0, 2));
    // hold over a load-use pair: stall masked, counter frozen
    tbl.push_back(ldw(6, 1, 2'b00, 2'b00, 0, 2));
    tbl.push_back(alu(13, 6, 1, 2'b00, 2'b00, 0, 2));
    tbl[tbl.size()-1].hd = 1'b1;
    tbl.push_back(alu(13, 6, 1, 2'b00, 2'b00, 0, 2));
    tbl[tbl.size()-1].hd = 1'b1;
    tbl.push_back(alu(13, 6, 1, 2'b00, 2'b00, 1, 2));
    tbl.push_back(alu(13, 6, 1, 2'b00, 2'b00, 0, 3));
    tbl.push_back(nop(2'b01, 2'b00, 0, 3));
    // hold while an EX_MEM forward is live: code stays put
    tbl.push_back(alu(14, 1, 1, 2'b00, 2'b00, 0, 3));
    tbl.push_back(alu(15, 14, 2, 2'b00, 2'b00, 0, 3));
    tbl.push_back(nop(2'b10, 2'b00, 0, 3));
    tbl[tbl.size()-1].hd = 1'b1;
    tbl.push_back(nop(2'b10, 2'b00, 0, 3));
    tbl[tbl.size()-1].hd = 1'b1;
    tbl.push_back(nop(2'b10, 2'b00, 0, 3));
    tbl.push_back(nop(2'b00, 2'b00, 0, 3));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_fa", {30'd0, forwardA}, 32'd0);
    chk("reset_fb", {30'd0, forwardB}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) run_row(i, tbl[i]);

    // saturation of the 3-bit counter while the 16-bit one keeps counting
    e_cnt = 3;
    for (int i = 0; i < 6; i++) begin
      drive(ldw(2, 9, 0, 0, 0, 0));
      tick();
      drive(alu(7, 2, 1, 0, 0, 0, 0));
      #3;
      chk("sat_stall_hi", {31'd0, stall}, 32'd1);
      tick();
      e_cnt++;
      #3;
      chk("sat_stall_lo", {31'd0, stall}, 32'd0);
      chk("sat_cnt16", {16'd0, stall_cnt}, e_cnt);
      chk("sat_cnt3", {29'd0, s_stall_cnt}, {29'd0, sat3(16'(e_cnt))});
      tick();
      drive(nop(0, 0, 0, 0));
      tick();
    end

    // asynchronous reset with a live forward and a pending stall
    drive(alu(3, 1, 1, 0, 0, 0, 0));
    tick();
    drive(ldw(3, 3, 0, 0, 0, 0));
    tick();
    drive(alu(7, 3, 1, 0, 0, 0, 0));
    #2;
    chk("pre_rst_fa", {30'd0, forwardA}, 32'd2);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_fa", {30'd0, forwardA}, 32'd0);
    chk("async_rst_fb", {30'd0, forwardB}, 32'd0);
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("async_rst_cnt3", {29'd0, s_stall_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(nop(0, 0, 0, 0));
    tick();
    #3;
    chk("post_rst_fa", {30'd0, forwardA}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
